// File: rtl/player_position_ctrl.sv
// Sprite position controller: synchronizes PS/2 direction flags, queues one step per
// direction and applies queued moves once per frame, clamped to the visible area.
module player_position_ctrl #(
    parameter int H_LIMIT  = 640,
    parameter int V_LIMIT  = 480,
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int STEP     = 8,
    parameter int START_X  = 312,
    parameter int START_Y  = 232
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic       FrameTick,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic       Moved
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] MAX_X  = 11'(H_LIMIT - SPRITE_W);
    localparam logic [10:0] MAX_Y  = 11'(V_LIMIT - SPRITE_H);

    // Direction vectors are ordered {up, down, left, right}
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] cmd_q, cmd_d;
    logic [3:0] edge_w;
    state_t     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    logic       moved_q, moved_d;
    logic [10:0] x_ext, y_ext, nx, ny;

    assign edge_w = sync2_q & ~prev_q;

    always_comb begin
        x_ext = {1'b0, pos_x_q};
        y_ext = {1'b0, pos_y_q};
        nx    = x_ext;
        ny    = y_ext;
        // Opposing directions in one snapshot cancel on that axis
        if (cmd_q[1] && !cmd_q[0]) begin
            nx = (x_ext >= STEP_W) ? x_ext - STEP_W : 11'd0;
        end else if (cmd_q[0] && !cmd_q[1]) begin
            nx = (x_ext + STEP_W > MAX_X) ? MAX_X : x_ext + STEP_W;
        end
        if (cmd_q[3] && !cmd_q[2]) begin
            ny = (y_ext >= STEP_W) ? y_ext - STEP_W : 11'd0;
        end else if (cmd_q[2] && !cmd_q[3]) begin
            ny = (y_ext + STEP_W > MAX_Y) ? MAX_Y : y_ext + STEP_W;
        end
    end

    always_comb begin
        sync1_d = {Up, Down, Left, Right};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        pend_d  = pend_q | edge_w;
        cmd_d   = cmd_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        moved_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend_q) state_d = PENDING;
            end
            PENDING: begin
                if (FrameTick) begin
                    cmd_d   = pend_q;
                    pend_d  = edge_w;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                pos_x_d = nx[9:0];
                pos_y_d = ny[9:0];
                moved_d = (nx[9:0] != pos_x_q) || (ny[9:0] != pos_y_q);
                state_d = (|pend_d) ? PENDING : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            cmd_q   <= '0;
            state_q <= IDLE;
            pos_x_q <= 10'(START_X);
            pos_y_q <= 10'(START_Y);
            moved_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            cmd_q   <= cmd_d;
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            moved_q <= moved_d;
        end
    end

    assign PosX  = pos_x_q;
    assign PosY  = pos_y_q;
    assign Moved = moved_q;

endmodule
